// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, I-cache request, miss/squash handling
// and halt, feeding the IF/ID register.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [3:0]  HALT_OP  = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  output logic [15:0] imem_addr,
  output logic        imem_re,
  input  logic [15:0] imem_data,
  input  logic        imem_ready,
  output logic [15:0] pc_inc,
  output logic [15:0] inst,
  output logic        ifid_we,
  output logic        ifid_clr,
  output logic        halted
);

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    MISS        = 2'd1,
    MISS_SQUASH = 2'd2,
    HALT        = 2'd3
  } state_t;

  state_t      state_r;
  logic [15:0] pc_r;
  logic [15:0] buf_r;
  logic [15:0] tgt_r;
  logic        buf_valid_r;
  logic        halted_r;
  logic        have_s;
  logic [15:0] inst_s;

  // An instruction is available either from the miss buffer or from the cache this cycle.
  assign have_s    = buf_valid_r | imem_ready;
  assign inst_s    = buf_valid_r ? buf_r : imem_data;
  assign imem_addr = pc_r;
  assign imem_re   = (state_r != HALT);
  assign pc_inc    = pc_r + 16'd2;
  assign inst      = inst_s;
  assign halted    = halted_r;

  // IF/ID control: branch squash beats stall, stall beats a missing instruction.
  always_comb begin
    ifid_we  = 1'b0;
    ifid_clr = 1'b0;
    if (!rst_n) begin
      ifid_clr = 1'b1;
    end else if (state_r == HALT) begin
      ifid_clr = br_taken;
    end else if (br_taken) begin
      ifid_clr = 1'b1;
    end else if (stall) begin
      ifid_we  = 1'b0;
      ifid_clr = 1'b0;
    end else if ((state_r == RUN) && have_s) begin
      ifid_we = 1'b1;
    end else begin
      ifid_clr = 1'b1;
    end
  end

  // Fetch sequencer: PC, miss buffer, saved redirect target and halt flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= RUN;
      pc_r        <= RESET_PC;
      buf_r       <= 16'h0000;
      buf_valid_r <= 1'b0;
      tgt_r       <= 16'h0000;
      halted_r    <= 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          if (br_taken) begin
            buf_valid_r <= 1'b0;
            if (have_s) begin
              pc_r <= br_target;
            end else begin
              tgt_r   <= br_target;
              state_r <= MISS_SQUASH;
            end
          end else if (stall) begin
            if (imem_ready && !buf_valid_r) begin
              buf_r       <= imem_data;
              buf_valid_r <= 1'b1;
            end
          end else if (have_s) begin
            buf_valid_r <= 1'b0;
            if (inst_s[15:12] == HALT_OP) begin
              state_r  <= HALT;
              halted_r <= 1'b1;
            end else begin
              pc_r <= pc_r + 16'd2;
            end
          end else begin
            state_r <= MISS;
          end
        end
        MISS: begin
          if (br_taken) begin
            buf_valid_r <= 1'b0;
            if (imem_ready) begin
              pc_r    <= br_target;
              state_r <= RUN;
            end else begin
              tgt_r   <= br_target;
              state_r <= MISS_SQUASH;
            end
          end else if (imem_ready) begin
            buf_r       <= imem_data;
            buf_valid_r <= 1'b1;
            state_r     <= RUN;
          end
        end
        MISS_SQUASH: begin
          // The fill for the stale address is dropped; the newest redirect wins.
          if (imem_ready) begin
            pc_r    <= br_taken ? br_target : tgt_r;
            state_r <= RUN;
          end else if (br_taken) begin
            tgt_r <= br_target;
          end
        end
        HALT: begin
          if (br_taken) begin
            pc_r        <= br_target;
            halted_r    <= 1'b0;
            buf_valid_r <= 1'b0;
            state_r     <= RUN;
          end
        end
        default: begin
          state_r <= RUN;
        end
      endcase
    end
  end

endmodule
